// File: rtl/word_mem_pkg.sv
// Shared word-RAM constants and state encodings for the store and readback paths.
// Used by word_tx_streamer and tx_byte_handshake.
package word_mem_pkg;

  localparam int WORD_W = 56;
  localparam int NBYTES = WORD_W / 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 5;

  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, RD, WT, LD, REQ, ACK, NXT
  } wtx_state_t;

  typedef enum logic [1:0] {
    H_IDLE, H_REQ, H_ACK
  } hs_state_t;

  function automatic logic [ADDR_W:0] clamp_words(
    input logic [ADDR_W:0] n
  );
    return (n > DEPTH_N) ? DEPTH_N : n;
  endfunction

endpackage

// File: rtl/word_tx_streamer_handshake.sv
// Level handshake toward uart_tx: one byte per go, done once the
// transmitter has taken the byte and gone idle again.
module tx_byte_handshake
  import word_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       ack,
  output logic       done
);

  hs_state_t state, state_n;

  // next state; go is also accepted while leaving ACK so bytes chain
  always_comb begin
    state_n = state;
    ack     = tx_start && tx_busy;
    done    = 1'b0;
    unique case (state)
      H_IDLE: if (go) state_n = H_REQ;
      H_REQ:  if (ack) state_n = H_ACK;
      H_ACK: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_n = go ? H_REQ : H_IDLE;
        end
      end
      default: state_n = H_IDLE;
    endcase
  end

  // request held while the transmitter is idle, dropped once it goes busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= H_IDLE;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      state <= state_n;
      if (go) tx_byte <= byte_in;
      if (state_n == H_REQ && !tx_busy) tx_start <= 1'b1;
      else if (ack) tx_start <= 1'b0;
    end
  end

endmodule

// File: rtl/word_tx_streamer.sv
// Streams stored program words out MSB byte first through uart_tx.
// WORD_TX_CHECKSUM_EN appends a two's-complement checksum byte.
module word_tx_streamer
  import word_mem_pkg::*;
(
  input  logic              CLK_UART_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_q_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_busy_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  wtx_state_t state, state_n;

  logic [WORD_W-1:0] shift;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   n_words;
  logic              zpend;
  logic              accept;
  logic              last_word;
  logic              go;
  logic [7:0]        byte_in;
  logic              hs_ack;
  logic              hs_done;
  logic              ck;

`ifdef WORD_TX_CHECKSUM_EN
  logic [7:0] sum;
`else
  assign ck = 1'b0;
`endif

  assign n_words   = clamp_words(num_words_i);
  assign accept    = (state == IDLE) && start_i && !busy_o;
  assign last_word = (word_cnt_o + 1'b1) == n_q;

  // word sequencing and selection of the next byte to hand over
  always_comb begin
    state_n = state;
    go      = 1'b0;
    byte_in = shift[WORD_W-1 -: 8];
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (n_words != '0) begin
            state_n = RD;
          end else begin
`ifdef WORD_TX_CHECKSUM_EN
            go      = 1'b1;
            byte_in = 8'h00;
            state_n = REQ;
`endif
          end
        end
      end
      RD: state_n = WT;
      WT: state_n = LD;
      LD: begin
        go      = 1'b1;
        byte_in = mem_q_i[WORD_W-1 -: 8];
        state_n = REQ;
      end
      REQ: if (hs_ack) state_n = ACK;
      ACK: begin
        if (hs_done) begin
          if (ck) begin
            state_n = IDLE;
          end else if (idx != LAST_IDX) begin
            go      = 1'b1;
            byte_in = shift[WORD_W-9 -: 8];
            state_n = REQ;
          end else begin
            state_n = NXT;
          end
        end
      end
      NXT: begin
        if (!last_word) begin
          state_n = RD;
        end else begin
`ifdef WORD_TX_CHECKSUM_EN
          go      = 1'b1;
          byte_in = 8'd0 - sum;
          state_n = REQ;
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register plus the word, byte and status bookkeeping
  always_ff @(posedge CLK_UART_i) begin
    if (rst_i) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      n_q        <= '0;
      zpend      <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      word_cnt_o <= '0;
`ifdef WORD_TX_CHECKSUM_EN
      ck         <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (zpend) begin
            zpend  <= 1'b0;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else if (accept) begin
            n_q        <= n_words;
            busy_o     <= 1'b1;
            word_cnt_o <= '0;
            mem_addr_o <= '0;
            if (n_words == '0) begin
`ifdef WORD_TX_CHECKSUM_EN
              ck <= 1'b1;
`else
              zpend <= 1'b1;
`endif
            end
          end
        end
        LD: begin
          shift <= mem_q_i;
          idx   <= '0;
        end
        ACK: begin
          if (hs_done) begin
            if (ck) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
              ck     <= 1'b0;
`endif
            end else if (idx != LAST_IDX) begin
              idx   <= idx + 1'b1;
              shift <= shift << 8;
            end
          end
        end
        NXT: begin
          word_cnt_o <= word_cnt_o + 1'b1;
          if (!last_word) begin
            mem_addr_o <= mem_addr_o + 1'b1;
          end else begin
`ifdef WORD_TX_CHECKSUM_EN
            ck <= 1'b1;
`else
            done_o <= 1'b1;
            busy_o <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WORD_TX_CHECKSUM_EN
  // running byte sum, restarted with every accepted stream
  always_ff @(posedge CLK_UART_i) begin
    if (rst_i || accept) sum <= '0;
    else if (go) sum <= sum + byte_in;
  end
`endif

  tx_byte_handshake u_hs (
    .clk      (CLK_UART_i),
    .rst      (rst_i),
    .go       (go),
    .byte_in  (byte_in),
    .tx_busy  (tx_busy_i),
    .tx_start (tx_start_o),
    .tx_byte  (tx_byte_o),
    .ack      (hs_ack),
    .done     (hs_done)
  );

endmodule

// File: tb/tb_word_tx_streamer.sv
// Scoreboard bench for word_tx_streamer with a RAM and uart_tx model.
// Build with +define+WORD_TX_CHECKSUM_EN to cover the checksum byte.
module tb_word_tx_streamer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  num_words_i;
  logic [2:0]  mem_addr_o;
  logic [55:0] mem_q_i;
  logic        tx_start_o;
  logic [7:0]  tx_byte_o;
  logic        tx_busy_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  word_cnt_o;

  logic [55:0] mem [8];
  logic [7:0]  sb [$];

  int   n_checks;
  int   n_errors;
  int   bcnt;
  logic hold;
  int   ncap;
  logic [7:0] cap_byte;
  int   unstable;
  int   addr_bad;
  int   start_in_hold;
  int   done_seen;
  int   base;

  word_tx_streamer dut (
    .CLK_UART_i  (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .num_words_i (num_words_i),
    .mem_addr_o  (mem_addr_o),
    .mem_q_i     (mem_q_i),
    .tx_start_o  (tx_start_o),
    .tx_byte_o   (tx_byte_o),
    .tx_busy_i   (tx_busy_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // synchronous RAM, one cycle read latency
  always @(posedge clk) mem_q_i <= mem[mem_addr_o];

  assign tx_busy_i = hold || (bcnt != 0);

  // uart_tx model: takes a byte, stays busy 10 cycles; plus monitors
  always @(negedge clk) begin
    if (rst_i) begin
      bcnt = 0;
    end else if (bcnt > 0) begin
      bcnt--;
      if (tx_byte_o !== cap_byte) unstable++;
    end else if (!hold && tx_start_o) begin
      cap_byte = tx_byte_o;
      ncap++;
      bcnt = 10;
      check("sb_has", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) check("tx_byte", tx_byte_o, sb.pop_front());
    end
    if (hold && tx_start_o) start_in_hold++;
    if (mem_addr_o > 3'd4) addr_bad++;
    if (done_o) done_seen++;
  end

  task automatic push_stream(input int n);
    int k;
    logic [55:0] wd;
    logic [7:0] b;
    logic [7:0] s;
    k = (n > 5) ? 5 : n;
    s = 8'h00;
    for (int w = 0; w < k; w++) begin
      wd = mem[w];
      for (int i = 0; i < 7; i++) begin
        b = wd[55 - 8*i -: 8];
        sb.push_back(b);
        s = s + b;
      end
    end
`ifdef WORD_TX_CHECKSUM_EN
    sb.push_back(8'h00 - s);
`endif
  endtask

  task automatic pulse_start(input int n);
    start_i = 1'b1;
    num_words_i = 4'(n);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_wc, input string tag);
    int cyc;
    cyc = 0;
    while (done_seen == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 64'(done_seen), 1);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_word_cnt"}, 64'(word_cnt_o), 64'(exp_wc));
    check({tag, "_sb_empty"}, 64'(sb.size()), 0);
  endtask

  int ck_extra;

  initial begin
    clk = 0;
    rst_i = 1;
    start_i = 0;
    num_words_i = 0;
    hold = 0;
    n_checks = 0;
    n_errors = 0;
    bcnt = 0;
    ncap = 0;
    unstable = 0;
    addr_bad = 0;
    start_in_hold = 0;
    done_seen = 0;
    cap_byte = 0;
`ifdef WORD_TX_CHECKSUM_EN
    ck_extra = 1;
`else
    ck_extra = 0;
`endif
    mem[0] = 56'h0123456789ABCD;
    mem[1] = 56'hFEDCBA98765432;
    mem[2] = 56'h11223344556677;
    mem[3] = 56'hA5A55A5AC3C33C;
    mem[4] = 56'h0F1E2D3C4B5A69;
    mem[5] = 56'hDEADDEADDEADDE;
    mem[6] = 56'hBADBADBADBADBA;
    mem[7] = 56'hCAFECAFECAFECA;

    repeat (3) @(negedge clk);
    check("reset_outs",
          {tx_start_o, tx_byte_o, busy_o, done_o, word_cnt_o, mem_addr_o},
          0);
    rst_i = 0;
    @(negedge clk);

    // one word, latency and byte order
    base = ncap;
    done_seen = 0;
    push_stream(1);
    pulse_start(1);
    @(negedge clk);
    @(negedge clk);
    check("lat_pre", 64'(tx_start_o), 0);
    @(negedge clk);
    check("lat_first", 64'(tx_start_o), 1);
    check("first_byte", tx_byte_o, 8'h01);
    wait_done(1, "w1");
    check("w1_nbytes", 64'(ncap - base), 64'(7 + ck_extra));

    // zero words
    base = ncap;
    done_seen = 0;
`ifdef WORD_TX_CHECKSUM_EN
    push_stream(0);
    pulse_start(0);
    wait_done(0, "w0");
    check("w0_nbytes", 64'(ncap - base), 1);
    check("w0_ck_byte", cap_byte, 8'h00);
`else
    start_i = 1;
    num_words_i = 0;
    @(negedge clk);
    start_i = 0;
    check("w0_busy_rise", {busy_o, done_o}, 2'b10);
    @(negedge clk);
    check("w0_done", {busy_o, done_o}, 2'b01);
    repeat (3) @(negedge clk);
    check("w0_done_cnt", 64'(done_seen), 1);
    check("w0_nbytes", 64'(ncap - base), 0);
    check("w0_word_cnt", 64'(word_cnt_o), 0);
`endif

    // clamped to DEPTH
    base = ncap;
    done_seen = 0;
    addr_bad = 0;
    push_stream(7);
    pulse_start(7);
    wait_done(5, "w7");
    check("w7_nbytes", 64'(ncap - base), 64'(35 + ck_extra));
    check("w7_addr_max", 64'(addr_bad), 0);

    // transmitter busy at first request
    base = ncap;
    done_seen = 0;
    unstable = 0;
    start_in_hold = 0;
    hold = 1;
    push_stream(1);
    pulse_start(1);
    repeat (50) @(negedge clk);
    check("hold_no_start", 64'(start_in_hold), 0);
    check("hold_busy", 64'(busy_o), 1);
    check("hold_nbytes", 64'(ncap - base), 0);
    hold = 0;
    wait_done(1, "hold");
    check("hold_stable", 64'(unstable), 0);

    // reset in the middle of a two-word stream
    base = ncap;
    done_seen = 0;
    push_stream(2);
    pulse_start(2);
    for (int c = 0; c < 1000 && (ncap - base) < 3; c++) @(negedge clk);
    check("rst_reached3", 64'((ncap - base) >= 3), 1);
    rst_i = 1;
    @(negedge clk);
    check("rst_outs",
          {tx_start_o, tx_byte_o, busy_o, done_o, word_cnt_o, mem_addr_o},
          0);
    rst_i = 0;
    sb.delete();
    repeat (20) @(negedge clk);
    check("rst_no_done", 64'(done_seen), 0);
    check("rst_idle_start", 64'(tx_start_o), 0);
    push_stream(1);
    pulse_start(1);
    wait_done(1, "resend");

    // second start while busy, all-ones-per-byte word
    mem[0] = 56'h01010101010101;
    base = ncap;
    done_seen = 0;
    push_stream(1);
    pulse_start(1);
    repeat (6) @(negedge clk);
    pulse_start(3);
    wait_done(1, "restart");
    check("restart_nbytes", 64'(ncap - base), 64'(7 + ck_extra));
`ifdef WORD_TX_CHECKSUM_EN
    check("ck_byte", cap_byte, 8'hF9);
`else
    check("last_byte", cap_byte, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
